uart_rx_frame_deser: RTL and testbench
======================================

// Module: uart_rx_frame_deser
// PURPOSE
//   Parametrised UART receive deserializer. It sits between the RX edge/bit counter and the RX
//   output interface, and it owns one received frame from the data bits to the stop bit.
//   It shifts DATA_WIDTH sampled bits in LSB- or MSB-first order, checks optional even/odd
//   parity and the stop bit, then commits the word to a holding register.
//   That register presents the word with a valid/ready handshake and sticky overrun detection.
// PARAMETERS
//   DATA_WIDTH   8   data bits per frame; legal range 5..9
//   EDGE_WIDTH   4   width of Edge_count
//   SAMPLE_EDGE  7   Edge_count value at which the sampled bit is taken
//   MSB_FIRST    0   0: first received bit -> P_Data_Deser[0]; 1: first bit -> P_Data_Deser[DATA_WIDTH-1]
// PORTS
//   CLK                in   1             system clock, rising edge
//   RST                in   1             asynchronous, active-high reset
//   Start_Det          in   1             1-cycle pulse: start bit confirmed, data bits follow
//   Deser_EN           in   1             frame enable from RX FSM; low aborts the frame
//   Edge_count         in   EDGE_WIDTH    oversampling edge counter
//   Sampled_Bit_Deser  in   1             majority-voted line value
//   PAR_EN             in   1             parity bit present
//   PAR_TYP            in   1             0 even, 1 odd
//   Data_Ready         in   1             consumer accepts P_Data_Deser this cycle
//   Ovr_Clr            in   1             clears Overrun
//   P_Data_Deser       out  DATA_WIDTH    received word, held while Data_Valid
//   Data_Valid         out  1             word available
//   Parity_Err         out  1             parity mismatch for the presented word
//   Stop_Err           out  1             stop bit sampled 0 for the presented word
//   Overrun            out  1             sticky: a frame completed while the holding register was full
//   Busy               out  1             state != IDLE
// BEHAVIOUR
//   - Reset: state IDLE, all outputs 0, shift register and bit counter 0.
//   - tick = Deser_EN && (Edge_count == SAMPLE_EDGE); every state transition below requires tick,
//     except the IDLE exit and the abort.
//   - IDLE: Start_Det=1 -> DATA; clear bit_cnt; latch PAR_EN/PAR_TYP. Mid-frame changes to either are ignored.
//   - DATA: each tick shifts in Sampled_Bit_Deser.
//     LSB-first: sr <= {bit, sr[W-1:1]}.  MSB-first: sr <= {sr[W-2:0], bit}.
//     On the DATA_WIDTH-th tick -> PARITY if the latched PAR_EN is 1, else -> STOP.
//   - PARITY: on tick, par_bad <= bit ^ (^sr) ^ PAR_TYP_latched, then -> STOP.
//     When parity is disabled, par_bad = 0.
//   - STOP: on tick, stop_bad <= ~bit, commit, then -> IDLE.
//   - Start_Det outside IDLE is ignored.
//   - Abort: Deser_EN=0 in DATA, PARITY or STOP -> IDLE next cycle. The partial frame is discarded;
//     output register and flags are unchanged.
//   - Commit (the cycle after the STOP tick):
//     * Holding register empty, or Data_Valid && Data_Ready in the same cycle: load P_Data_Deser,
//       Parity_Err, Stop_Err from the frame; Data_Valid=1.
//     * Holding register full and not accepted: new frame dropped, old word and flags kept, Overrun <= 1.
//   - Latency: Data_Valid rises 1 CLK after the stop-bit tick.
//   - Handshake:
//     * Data_Valid stays high, with data stable, until a cycle with Data_Ready=1.
//     * Data_Valid falls the next cycle unless a commit coincides.
//     * Data_Ready while Data_Valid=0 has no effect.
//   - Overrun: cleared by Ovr_Clr. Simultaneous set and clear -> set wins.
//   - bit_cnt is $clog2(DATA_WIDTH+1) bits and never wraps; it is reset on entry to DATA.
//   - RST mid-frame: immediate return to reset state; no partial commit.
// STRUCTURE
//   - Shared package uart_pkg:
//     * state encoding (IDLE=2'd0, DATA=2'd1, PARITY=2'd2, STOP=2'd3)
//     * parity constants (PAR_EVEN=1'b0, PAR_ODD=1'b1)
//     * DATA_WIDTH legal-range limits
//   - Sub-module uart_rx_out_reg: holding register, Data_Valid/Data_Ready handshake, error flags, Overrun.
//   - Top level keeps the FSM, bit counter and shift register.
// TESTING
//   1. W=8 LSB-first, no parity: bits 1,0,1,0,0,1,0,1 + stop 1
//      -> P_Data_Deser=8'hA5, Data_Valid=1 one CLK after stop tick, errors 0.
//   2. MSB_FIRST=1, PAR_EN=1, PAR_TYP=1, data 8'h3C, parity bit 0
//      -> Parity_Err=1 (odd expects 1). Same frame with parity bit 1 -> Parity_Err=0.
//   3. Stop bit sampled 0 on 8'h55 -> Stop_Err=1, word still presented as 8'h55.
//   4. Frame 8'h11 left unaccepted, frame 8'h22 completes -> P_Data_Deser stays 8'h11, Overrun=1.
//      Repeat with Data_Ready=1 in the commit cycle -> 8'h22 loaded, Overrun=0.
//   5. Deser_EN dropped after 4 data bits -> Busy=0 next CLK, Data_Valid and P_Data_Deser unchanged.
//      Then a full frame 8'hC3 is received correctly.
//   6. W=5 and W=9 builds: frames 5'h1B and 9'h1F0 received in both bit orders.
//      RST asserted mid-frame clears all outputs asynchronously.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, parity
// polarity constants, legal data-width range and the parity check helper.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int DW_MIN = 5;
    localparam int DW_MAX = 9;

    // True when the received parity bit disagrees with the data word for the
    // selected parity type (even: total ones even, odd: total ones odd).
    function automatic logic parity_bad(input logic [DW_MAX-1:0] data,
                                        input logic              par_bit,
                                        input logic              par_typ);
        return par_bit ^ (^data) ^ par_typ;
    endfunction

endpackage

// File: rtl/uart_rx_out_reg.sv
// Output holding register of the RX deserializer: presents one word with a
// valid/ready handshake, its error flags, and a sticky overrun flag.
module uart_rx_out_reg
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  commit_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  par_err_i,
    input  logic                  stop_err_i,
    input  logic                  data_ready_i,
    input  logic                  ovr_clr_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  par_err_o,
    output logic                  stop_err_o,
    output logic                  overrun_o
);

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stop_err_q, stop_err_d;
    logic                  ovr_q, ovr_d;
    logic                  accept_s;

    // Next-state: load on commit when the slot is free (or being freed), else
    // drop the frame and flag overrun; overrun set has priority over clear.
    always_comb begin
        data_d     = data_q;
        valid_d    = valid_q;
        par_err_d  = par_err_q;
        stop_err_d = stop_err_q;
        ovr_d      = ovr_q;
        accept_s   = valid_q && data_ready_i;

        if (commit_i && (!valid_q || accept_s)) begin
            data_d     = data_i;
            par_err_d  = par_err_i;
            stop_err_d = stop_err_i;
            valid_d    = 1'b1;
        end else if (accept_s) begin
            valid_d    = 1'b0;
        end else begin
            valid_d    = valid_q;
        end

        if (commit_i && valid_q && !accept_s) begin
            ovr_d = 1'b1;
        end else if (ovr_clr_i) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    // Holding register flops with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q     <= '0;
            valid_q    <= 1'b0;
            par_err_q  <= 1'b0;
            stop_err_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            data_q     <= data_d;
            valid_q    <= valid_d;
            par_err_q  <= par_err_d;
            stop_err_q <= stop_err_d;
            ovr_q      <= ovr_d;
        end
    end

    assign data_o     = data_q;
    assign valid_o    = valid_q;
    assign par_err_o  = par_err_q;
    assign stop_err_o = stop_err_q;
    assign overrun_o  = ovr_q;

endmodule

// File: rtl/uart_rx_frame_deser.sv
// UART receive deserializer: frame FSM, bit counter and shift register for
// one frame (data, optional parity, stop), committing into uart_rx_out_reg.
module uart_rx_frame_deser
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int EDGE_WIDTH  = 4,
    parameter int SAMPLE_EDGE = 7,
    parameter int MSB_FIRST   = 0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Start_Det,
    input  logic                  Deser_EN,
    input  logic [EDGE_WIDTH-1:0] Edge_count,
    input  logic                  Sampled_Bit_Deser,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  Data_Ready,
    input  logic                  Ovr_Clr,
    output logic [DATA_WIDTH-1:0] P_Data_Deser,
    output logic                  Data_Valid,
    output logic                  Parity_Err,
    output logic                  Stop_Err,
    output logic                  Overrun,
    output logic                  Busy
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    if (DATA_WIDTH < DW_MIN || DATA_WIDTH > DW_MAX) begin : g_bad_width
        $error("uart_rx_frame_deser: DATA_WIDTH out of range");
    end

    rx_state_e             state_q, state_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] sr_q, sr_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  par_bad_q, par_bad_d;
    logic                  tick_s;
    logic                  commit_s;
    logic [DW_MAX-1:0]     sr_ext_s;

    // Frame FSM next-state, shifting, parity evaluation and commit strobe.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sr_d      = sr_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        par_bad_d = par_bad_q;
        commit_s  = 1'b0;
        tick_s    = Deser_EN && (Edge_count == EDGE_WIDTH'(SAMPLE_EDGE));
        sr_ext_s  = '0;
        sr_ext_s[DATA_WIDTH-1:0] = sr_q;

        case (state_q)
            ST_IDLE: begin
                if (Start_Det) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    par_bad_d = 1'b0;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (!Deser_EN) begin
                    state_d = ST_IDLE;
                end else if (tick_s) begin
                    if (MSB_FIRST != 0) begin
                        sr_d = {sr_q[DATA_WIDTH-2:0], Sampled_Bit_Deser};
                    end else begin
                        sr_d = {Sampled_Bit_Deser, sr_q[DATA_WIDTH-1:1]};
                    end
                    bit_cnt_d = bit_cnt_q + CW'(1);
                    if (bit_cnt_q == CW'(DATA_WIDTH - 1)) begin
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (!Deser_EN) begin
                    state_d = ST_IDLE;
                end else if (tick_s) begin
                    par_bad_d = parity_bad(sr_ext_s, Sampled_Bit_Deser, par_typ_q);
                    state_d   = ST_STOP;
                end else begin
                    state_d   = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (!Deser_EN) begin
                    state_d  = ST_IDLE;
                end else if (tick_s) begin
                    commit_s = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    state_d  = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Frame state flops with asynchronous reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            sr_q      <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= PAR_EVEN;
            par_bad_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            sr_q      <= sr_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            par_bad_q <= par_bad_d;
        end
    end

    assign Busy = (state_q != ST_IDLE);

    uart_rx_out_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_reg (
        .clk          (CLK),
        .rst          (RST),
        .commit_i     (commit_s),
        .data_i       (sr_q),
        .par_err_i    (par_bad_q),
        .stop_err_i   (~Sampled_Bit_Deser),
        .data_ready_i (Data_Ready),
        .ovr_clr_i    (Ovr_Clr),
        .data_o       (P_Data_Deser),
        .valid_o      (Data_Valid),
        .par_err_o    (Parity_Err),
        .stop_err_o   (Stop_Err),
        .overrun_o    (Overrun)
    );

endmodule

// File: tb/tb_uart_rx_frame_deser.sv
// Directed bench for uart_rx_frame_deser: six instances covering W=8/5/9 in
// both bit orders, each with its own Start_Det/Deser_EN/Data_Ready.
module tb_uart_rx_frame_deser;

    logic       CLK = 1'b0;
    logic       RST;
    logic [5:0] start_v, en_v, rdy_v;
    logic [3:0] edge_cnt;
    logic       sbit, par_en, par_typ, ovr_clr;

    int tests  = 0;
    int failed = 0;

    logic [7:0] d8l_data, d8m_data;
    logic [4:0] d5l_data, d5m_data;
    logic [8:0] d9l_data, d9m_data;
    logic [5:0] dv, pe, se, ovr, busy;

    always #5 CLK = ~CLK;

    uart_rx_frame_deser #(.DATA_WIDTH(8), .MSB_FIRST(0)) d8l (
        .CLK(CLK), .RST(RST), .Start_Det(start_v[0]), .Deser_EN(en_v[0]), .Edge_count(edge_cnt),
        .Sampled_Bit_Deser(sbit), .PAR_EN(par_en), .PAR_TYP(par_typ), .Data_Ready(rdy_v[0]),
        .Ovr_Clr(ovr_clr), .P_Data_Deser(d8l_data), .Data_Valid(dv[0]), .Parity_Err(pe[0]),
        .Stop_Err(se[0]), .Overrun(ovr[0]), .Busy(busy[0]));
    uart_rx_frame_deser #(.DATA_WIDTH(8), .MSB_FIRST(1)) d8m (
        .CLK(CLK), .RST(RST), .Start_Det(start_v[1]), .Deser_EN(en_v[1]), .Edge_count(edge_cnt),
        .Sampled_Bit_Deser(sbit), .PAR_EN(par_en), .PAR_TYP(par_typ), .Data_Ready(rdy_v[1]),
        .Ovr_Clr(ovr_clr), .P_Data_Deser(d8m_data), .Data_Valid(dv[1]), .Parity_Err(pe[1]),
        .Stop_Err(se[1]), .Overrun(ovr[1]), .Busy(busy[1]));
    uart_rx_frame_deser #(.DATA_WIDTH(5), .MSB_FIRST(0)) d5l (
        .CLK(CLK), .RST(RST), .Start_Det(start_v[2]), .Deser_EN(en_v[2]), .Edge_count(edge_cnt),
        .Sampled_Bit_Deser(sbit), .PAR_EN(par_en), .PAR_TYP(par_typ), .Data_Ready(rdy_v[2]),
        .Ovr_Clr(ovr_clr), .P_Data_Deser(d5l_data), .Data_Valid(dv[2]), .Parity_Err(pe[2]),
        .Stop_Err(se[2]), .Overrun(ovr[2]), .Busy(busy[2]));
    uart_rx_frame_deser #(.DATA_WIDTH(5), .MSB_FIRST(1)) d5m (
        .CLK(CLK), .RST(RST), .Start_Det(start_v[3]), .Deser_EN(en_v[3]), .Edge_count(edge_cnt),
        .Sampled_Bit_Deser(sbit), .PAR_EN(par_en), .PAR_TYP(par_typ), .Data_Ready(rdy_v[3]),
        .Ovr_Clr(ovr_clr), .P_Data_Deser(d5m_data), .Data_Valid(dv[3]), .Parity_Err(pe[3]),
        .Stop_Err(se[3]), .Overrun(ovr[3]), .Busy(busy[3]));
    uart_rx_frame_deser #(.DATA_WIDTH(9), .MSB_FIRST(0)) d9l (
        .CLK(CLK), .RST(RST), .Start_Det(start_v[4]), .Deser_EN(en_v[4]), .Edge_count(edge_cnt),
        .Sampled_Bit_Deser(sbit), .PAR_EN(par_en), .PAR_TYP(par_typ), .Data_Ready(rdy_v[4]),
        .Ovr_Clr(ovr_clr), .P_Data_Deser(d9l_data), .Data_Valid(dv[4]), .Parity_Err(pe[4]),
        .Stop_Err(se[4]), .Overrun(ovr[4]), .Busy(busy[4]));
    uart_rx_frame_deser #(.DATA_WIDTH(9), .MSB_FIRST(1)) d9m (
        .CLK(CLK), .RST(RST), .Start_Det(start_v[5]), .Deser_EN(en_v[5]), .Edge_count(edge_cnt),
        .Sampled_Bit_Deser(sbit), .PAR_EN(par_en), .PAR_TYP(par_typ), .Data_Ready(rdy_v[5]),
        .Ovr_Clr(ovr_clr), .P_Data_Deser(d9m_data), .Data_Valid(dv[5]), .Parity_Err(pe[5]),
        .Stop_Err(se[5]), .Overrun(ovr[5]), .Busy(busy[5]));

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clk1();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_bit(input logic b);
        for (int e = 0; e < 16; e++) begin
            edge_cnt = 4'(e);
            sbit     = b;
            clk1();
        end
    endtask

    task automatic start_frame(input int idx, input logic pen, input logic ptyp);
        start_v[idx] = 1'b1;
        en_v[idx]    = 1'b1;
        par_en       = pen;
        par_typ      = ptyp;
        edge_cnt     = 4'd0;
        clk1();
        start_v[idx] = 1'b0;
        par_en       = ~pen;   // mid-frame changes must be ignored
        par_typ      = ~ptyp;
    endtask

    // Sends a whole frame and stops with Edge_count=7 on the stop bit, just
    // before the stop-tick clock edge.
    task automatic run_frame(input int idx, input logic [8:0] data, input int n, input logic msb,
                             input logic pen, input logic ptyp, input logic pbit, input logic stopb);
        start_frame(idx, pen, ptyp);
        for (int i = 0; i < n; i++) begin
            send_bit(msb ? data[n-1-i] : data[i]);
        end
        if (pen) begin
            send_bit(pbit);
        end
        for (int e = 0; e < 7; e++) begin
            edge_cnt = 4'(e);
            sbit     = stopb;
            clk1();
        end
        edge_cnt = 4'd7;
        sbit     = stopb;
    endtask

    task automatic stop_edge();
        clk1();
        edge_cnt = 4'd8;
    endtask

    task automatic accept(input int idx);
        rdy_v[idx] = 1'b1;
        clk1();
        rdy_v[idx] = 1'b0;
    endtask

    initial begin
        RST = 1'b1; start_v = '0; en_v = '1; rdy_v = '0; edge_cnt = 4'd0;
        sbit = 1'b1; par_en = 1'b0; par_typ = 1'b0; ovr_clr = 1'b0;
        #3;
        check("reset_dv",   9'(dv),   9'h000);
        check("reset_busy", 9'(busy), 9'h000);
        check("reset_data", 9'(d8l_data), 9'h000);
        clk1(); clk1();
        RST = 1'b0;
        clk1();

        // 1: A5 LSB-first, no parity
        run_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t1_dv_before_tick", 9'(dv[0]), 9'h000);
        check("t1_busy_before",    9'(busy[0]), 9'h001);
        stop_edge();
        check("t1_dv",   9'(dv[0]), 9'h001);
        check("t1_data", 9'(d8l_data), 9'h0A5);
        check("t1_pe",   9'(pe[0]), 9'h000);
        check("t1_se",   9'(se[0]), 9'h000);
        check("t1_busy", 9'(busy[0]), 9'h000);
        clk1(); clk1();
        check("t1_hold_dv",   9'(dv[0]), 9'h001);
        check("t1_hold_data", 9'(d8l_data), 9'h0A5);
        accept(0);
        check("t1_dv_after_accept", 9'(dv[0]), 9'h000);
        accept(0);
        check("t1_ready_idle_no_effect", 9'(dv[0]), 9'h000);

        // 2: MSB-first, odd parity on 3C
        run_frame(1, 9'h03C, 8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        stop_edge();
        check("t2a_data", 9'(d8m_data), 9'h03C);
        check("t2a_pe",   9'(pe[1]), 9'h001);
        accept(1);
        run_frame(1, 9'h03C, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        stop_edge();
        check("t2b_data", 9'(d8m_data), 9'h03C);
        check("t2b_pe",   9'(pe[1]), 9'h000);
        check("t2b_dv",   9'(dv[1]), 9'h001);
        accept(1);

        // 3: stop error on 55
        run_frame(0, 9'h055, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        stop_edge();
        check("t3_se",   9'(se[0]), 9'h001);
        check("t3_data", 9'(d8l_data), 9'h055);
        check("t3_dv",   9'(dv[0]), 9'h001);
        accept(0);

        // 4: overrun, then simultaneous accept+commit, then set-beats-clear
        run_frame(0, 9'h011, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        stop_edge();
        check("t4_first", 9'(d8l_data), 9'h011);
        run_frame(0, 9'h022, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        stop_edge();
        check("t4_ovr_data", 9'(d8l_data), 9'h011);
        check("t4_ovr",      9'(ovr[0]), 9'h001);
        check("t4_ovr_se",   9'(se[0]), 9'h000);
        ovr_clr = 1'b1; clk1(); ovr_clr = 1'b0;
        check("t4_ovr_clr",  9'(ovr[0]), 9'h000);
        run_frame(0, 9'h022, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        rdy_v[0] = 1'b1;
        stop_edge();
        rdy_v[0] = 1'b0;
        check("t4_swap_data", 9'(d8l_data), 9'h022);
        check("t4_swap_dv",   9'(dv[0]), 9'h001);
        check("t4_swap_ovr",  9'(ovr[0]), 9'h000);
        run_frame(0, 9'h033, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        ovr_clr = 1'b1;
        stop_edge();
        ovr_clr = 1'b0;
        check("t4_set_wins", 9'(ovr[0]), 9'h001);
        check("t4_keep_22",  9'(d8l_data), 9'h022);
        ovr_clr = 1'b1; clk1(); ovr_clr = 1'b0;

        // 5: abort after 4 data bits, word 22 still presented
        start_frame(0, 1'b0, 1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        check("t5_busy_mid", 9'(busy[0]), 9'h001);
        en_v[0] = 1'b0;
        clk1();
        en_v[0] = 1'b1;
        check("t5_busy_abort", 9'(busy[0]), 9'h000);
        check("t5_dv_kept",    9'(dv[0]), 9'h001);
        check("t5_data_kept",  9'(d8l_data), 9'h022);
        accept(0);
        run_frame(0, 9'h0C3, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        stop_edge();
        check("t5_c3", 9'(d8l_data), 9'h0C3);
        check("t5_c3_dv", 9'(dv[0]), 9'h001);
        accept(0);

        // 6: W=5 and W=9, both orders
        run_frame(2, 9'h01B, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); stop_edge();
        check("t6_w5_lsb", 9'(d5l_data), 9'h01B);
        run_frame(3, 9'h01B, 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1); stop_edge();
        check("t6_w5_msb", 9'(d5m_data), 9'h01B);
        run_frame(4, 9'h1F0, 9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); stop_edge();
        check("t6_w9_lsb", d9l_data, 9'h1F0);
        run_frame(5, 9'h1F0, 9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1); stop_edge();
        check("t6_w9_msb", d9m_data, 9'h1F0);
        check("t6_dv_all", 9'(dv[5:2]), 9'h00F);

        // RST mid-frame clears asynchronously
        start_frame(4, 1'b0, 1'b0);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        check("rst_busy_before", 9'(busy[4]), 9'h001);
        RST = 1'b1;
        #1;
        check("rst_async_dv",   9'(dv), 9'h000);
        check("rst_async_busy", 9'(busy), 9'h000);
        check("rst_async_data", d9l_data, 9'h000);
        clk1();
        RST = 1'b0;
        clk1();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
